// File: rtl/coin_credit_fsm.sv
// -----------------------------------------------------------------------------
// coin_credit_fsm
//   Vending-path controller sitting after the coin-value decoder. Accumulates
//   credit from accepted coins, issues a one-cycle dispense pulse (with change)
//   once credit reaches PRICE, and handles cancel/refund of collected credit.
//
// Ports:
//   i_clk           system clock, all state updates on the rising edge
//   i_rst_n         synchronous active-low reset
//   i_coin_val      coin value from the decoder (0..63 legal)
//   i_coin_valid    coin present this cycle
//   o_coin_ready    coin accepted when i_coin_valid && o_coin_ready
//   i_cancel        level request to refund current credit
//   o_credit        current accumulated credit (registered)
//   o_dispense      one-cycle vend pulse
//   o_change        change/refund amount, valid with o_change_valid, else 0
//   o_change_valid  one-cycle pulse: return o_change
//   o_busy          high while dispensing or refunding
// -----------------------------------------------------------------------------
module coin_credit_fsm #(
    parameter int PRICE = 20,
    parameter int WIDTH = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_coin_val,
    input  logic             i_coin_valid,
    output logic             o_coin_ready,
    input  logic             i_cancel,
    output logic [WIDTH-1:0] o_credit,
    output logic             o_dispense,
    output logic [WIDTH-1:0] o_change,
    output logic             o_change_valid,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_DISPENSE = 2'd2,
        S_REFUND   = 2'd3
    } state_t;

    localparam logic [WIDTH:0] PRICE_W = (WIDTH+1)'(PRICE);

    state_t           r_state;
    logic [WIDTH-1:0] r_credit;
    logic [WIDTH-1:0] r_change;
    logic             r_dispense;
    logic             r_change_valid;
    logic             r_busy;

    logic             w_ready;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_over;

    // Readiness is decoded from state only; held low while reset is asserted.
    assign w_ready      = (r_state == S_IDLE) || (r_state == S_COLLECT);
    assign o_coin_ready = w_ready & i_rst_n;

    // Sum is one bit wider than credit so the PRICE compare never wraps.
    assign w_sum  = {1'b0, r_credit} + {1'b0, i_coin_val};
    assign w_over = w_sum - PRICE_W;

    assign o_credit       = r_credit;
    assign o_dispense     = r_dispense;
    assign o_change       = r_change;
    assign o_change_valid = r_change_valid;
    assign o_busy         = r_busy;

    // Credit FSM with registered vend/change/busy outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_credit       <= {WIDTH{1'b0}};
            r_change       <= {WIDTH{1'b0}};
            r_dispense     <= 1'b0;
            r_change_valid <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_COLLECT: begin
                    if (i_coin_valid) begin
                        if (w_sum >= PRICE_W) begin
                            // Enough credit: vend; a simultaneous cancel is ignored.
                            r_state        <= S_DISPENSE;
                            r_credit       <= w_sum[WIDTH-1:0];
                            r_change       <= w_over[WIDTH-1:0];
                            r_dispense     <= 1'b1;
                            r_change_valid <= (w_sum > PRICE_W);
                            r_busy         <= 1'b1;
                        end else if (w_sum != {(WIDTH+1){1'b0}}) begin
                            r_credit   <= w_sum[WIDTH-1:0];
                            r_dispense <= 1'b0;
                            if (i_cancel) begin
                                // Coin is counted first, then the whole sum is refunded.
                                r_state        <= S_REFUND;
                                r_change       <= w_sum[WIDTH-1:0];
                                r_change_valid <= 1'b1;
                                r_busy         <= 1'b1;
                            end else begin
                                r_state        <= S_COLLECT;
                                r_change       <= {WIDTH{1'b0}};
                                r_change_valid <= 1'b0;
                                r_busy         <= 1'b0;
                            end
                        end else begin
                            // Zero-value coin with no credit: nothing to do.
                            r_state        <= S_IDLE;
                            r_change       <= {WIDTH{1'b0}};
                            r_dispense     <= 1'b0;
                            r_change_valid <= 1'b0;
                            r_busy         <= 1'b0;
                        end
                    end else if (i_cancel && (r_state == S_COLLECT)) begin
                        r_state        <= S_REFUND;
                        r_change       <= r_credit;
                        r_dispense     <= 1'b0;
                        r_change_valid <= 1'b1;
                        r_busy         <= 1'b1;
                    end else begin
                        r_change       <= {WIDTH{1'b0}};
                        r_dispense     <= 1'b0;
                        r_change_valid <= 1'b0;
                        r_busy         <= 1'b0;
                    end
                end
                S_DISPENSE, S_REFUND: begin
                    // Single-cycle pulse states; coins offered here are dropped.
                    r_state        <= S_IDLE;
                    r_credit       <= {WIDTH{1'b0}};
                    r_change       <= {WIDTH{1'b0}};
                    r_dispense     <= 1'b0;
                    r_change_valid <= 1'b0;
                    r_busy         <= 1'b0;
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_credit       <= {WIDTH{1'b0}};
                    r_change       <= {WIDTH{1'b0}};
                    r_dispense     <= 1'b0;
                    r_change_valid <= 1'b0;
                    r_busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule
